// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the register file write port
//
// Shares the single register file write port between the ALU writeback path
// (requester 0) and the load writeback path (requester 1). The winning request
// is registered onto the write port; the register file commits it one edge later.
// Writes to register 31 complete the handshake but never raise regWrite.
//
// Ports:
//   CLOCK, RESET_N              clock, synchronous active-low reset
//   hold                        stall; no grant while high
//   req0Valid/Address/Data      ALU writeback request
//   req0Ready                   combinational grant to requester 0
//   req1Valid/Address/Data      load writeback request
//   req1Ready                   combinational grant to requester 1
//   regWrite                    registered write enable
//   writeAddress, writeData     registered write address and data
//   conflictCount               saturating count of contested, non-held cycles
module regfile_write_arbiter #(
   parameter int DATA_WIDTH     = 64,
   parameter int ADDR_WIDTH     = 5,
   parameter int CONFLICT_WIDTH = 8
) (
   input  logic                      CLOCK,
   input  logic                      RESET_N,
   input  logic                      hold,
   input  logic                      req0Valid,
   input  logic [ADDR_WIDTH-1:0]     req0Address,
   input  logic [DATA_WIDTH-1:0]     req0Data,
   output logic                      req0Ready,
   input  logic                      req1Valid,
   input  logic [ADDR_WIDTH-1:0]     req1Address,
   input  logic [DATA_WIDTH-1:0]     req1Data,
   output logic                      req1Ready,
   output logic                      regWrite,
   output logic [ADDR_WIDTH-1:0]     writeAddress,
   output logic [DATA_WIDTH-1:0]     writeData,
   output logic [CONFLICT_WIDTH-1:0] conflictCount
);

   localparam logic [ADDR_WIDTH-1:0]     ZERO_REG  = ADDR_WIDTH'(31);
   localparam logic [CONFLICT_WIDTH-1:0] COUNT_MAX = '1;

   // 0: requester 0 wins a tie, 1: requester 1 wins a tie
   logic prio;
   logic xfer0;
   logic xfer1;
   logic contested;

   // Grants are one-hot or zero; a lone valid requester always wins,
   // prio only matters when both are asking.
   always_comb begin
      req0Ready = 1'b0;
      req1Ready = 1'b0;
      if (RESET_N && !hold) begin
         if (req0Valid && req1Valid) begin
            req0Ready = !prio;
            req1Ready = prio;
         end else begin
            req0Ready = req0Valid;
            req1Ready = req1Valid;
         end
      end
   end

   assign xfer0     = req0Valid && req0Ready;
   assign xfer1     = req1Valid && req1Ready;
   assign contested = req0Valid && req1Valid && !hold;

   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         prio          <= 1'b0;
         regWrite      <= 1'b0;
         writeAddress  <= '0;
         writeData     <= '0;
         conflictCount <= '0;
      end else begin
         regWrite <= 1'b0;
         if (xfer0) begin
            writeAddress <= req0Address;
            writeData    <= req0Data;
            regWrite     <= (req0Address != ZERO_REG);
            prio         <= 1'b1;
         end else if (xfer1) begin
            writeAddress <= req1Address;
            writeData    <= req1Data;
            regWrite     <= (req1Address != ZERO_REG);
            prio         <= 1'b0;
         end
         if (contested && (conflictCount != COUNT_MAX)) begin
            conflictCount <= conflictCount + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

   logic        CLOCK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        hold = 1'b0;
   logic        req0Valid = 1'b0;
   logic [4:0]  req0Address = '0;
   logic [63:0] req0Data = '0;
   logic        req0Ready;
   logic        req1Valid = 1'b0;
   logic [4:0]  req1Address = '0;
   logic [63:0] req1Data = '0;
   logic        req1Ready;
   logic        regWrite;
   logic [4:0]  writeAddress;
   logic [63:0] writeData;
   logic [7:0]  conflictCount;

   regfile_write_arbiter #(
      .DATA_WIDTH(64),
      .ADDR_WIDTH(5),
      .CONFLICT_WIDTH(8)
   ) dut (
      .CLOCK(CLOCK),
      .RESET_N(RESET_N),
      .hold(hold),
      .req0Valid(req0Valid),
      .req0Address(req0Address),
      .req0Data(req0Data),
      .req0Ready(req0Ready),
      .req1Valid(req1Valid),
      .req1Address(req1Address),
      .req1Data(req1Data),
      .req1Ready(req1Ready),
      .regWrite(regWrite),
      .writeAddress(writeAddress),
      .writeData(writeData),
      .conflictCount(conflictCount)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [63:0] data;
      logic [7:0]  count;
   } expect_t;

   expect_t sbq[$];

   int testsRun = 0;
   int testsFailed = 0;

   // reference model state
   logic        mPrio = 1'b0;
   logic [4:0]  mAddr = '0;
   logic [63:0] mData = '0;
   logic [7:0]  mCount = '0;

   // readies observed in the most recent step
   logic obs0;
   logic obs1;

   task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock cycle: drive inputs, check readies against the model, advance
   // the model at the edge, then pop and check the registered outputs.
   task automatic step(input logic rn, input logic h,
                       input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [63:0] d1);
      logic    e0;
      logic    e1;
      expect_t ex;
      expect_t got;
      RESET_N = rn; hold = h;
      req0Valid = v0; req0Address = a0; req0Data = d0;
      req1Valid = v1; req1Address = a1; req1Data = d1;
      #1;
      e0 = 1'b0;
      e1 = 1'b0;
      if (rn && !h) begin
         if (v0 && v1) begin
            e0 = !mPrio;
            e1 = mPrio;
         end else begin
            e0 = v0;
            e1 = v1;
         end
      end
      obs0 = req0Ready;
      obs1 = req1Ready;
      chk("req0Ready", {63'd0, req0Ready}, {63'd0, e0});
      chk("req1Ready", {63'd0, req1Ready}, {63'd0, e1});
      @(posedge CLOCK);
      if (!rn) begin
         mPrio = 1'b0; mAddr = '0; mData = '0; mCount = '0;
         ex.we = 1'b0;
      end else begin
         ex.we = 1'b0;
         if (e0 && v0) begin
            mAddr = a0; mData = d0; ex.we = (a0 != 5'd31); mPrio = 1'b1;
         end else if (e1 && v1) begin
            mAddr = a1; mData = d1; ex.we = (a1 != 5'd31); mPrio = 1'b0;
         end
         if (v0 && v1 && !h && mCount != 8'hFF) mCount = mCount + 8'd1;
      end
      ex.addr = mAddr; ex.data = mData; ex.count = mCount;
      sbq.push_back(ex);
      #1;
      got = sbq.pop_front();
      chk("regWrite", {63'd0, regWrite}, {63'd0, got.we});
      chk("writeAddress", {59'd0, writeAddress}, {59'd0, got.addr});
      chk("writeData", writeData, got.data);
      chk("conflictCount", {56'd0, conflictCount}, {56'd0, got.count});
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
   endtask

   initial begin
      // reset with both requesters asking
      step(1'b0, 1'b0, 1'b1, 5'd7, 64'h77, 1'b1, 5'd8, 64'h88);
      step(1'b0, 1'b0, 1'b1, 5'd7, 64'h77, 1'b1, 5'd8, 64'h88);
      chk("reset_ready0", {63'd0, obs0}, 64'd0);
      chk("reset_count", {56'd0, conflictCount}, 64'd0);
      chk("reset_regWrite", {63'd0, regWrite}, 64'd0);

      // first cycle after release: requester 0 wins the tie
      step(1'b1, 1'b0, 1'b1, 5'd7, 64'h77, 1'b1, 5'd8, 64'h88);
      chk("release_grant0", {63'd0, obs0}, 64'd1);
      chk("release_data", writeData, 64'h77);
      idle();

      // single requester 1
      step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'h10);
      chk("single_ready1", {63'd0, obs1}, 64'd1);
      chk("single_addr", {59'd0, writeAddress}, 64'd3);
      chk("single_data", writeData, 64'h10);
      idle();
      chk("single_drop", {63'd0, regWrite}, 64'd0);

      // contention from a fresh reset: 0,1,0,1
      step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b1, 5'd1, 64'h100 + 64'(i), 1'b1, 5'd2, 64'h200 + 64'(i));
         chk("contend_grant1", {63'd0, obs1}, 64'(i % 2));
         chk("contend_we", {63'd0, regWrite}, 64'd1);
      end
      chk("contend_count", {56'd0, conflictCount}, 64'd4);
      chk("contend_last", writeData, 64'h203);

      // zero register write: handshake completes, no regWrite, prio flips
      step(1'b1, 1'b0, 1'b1, 5'd31, 64'hFF, 1'b0, 5'd0, 64'd0);
      chk("zero_ready0", {63'd0, obs0}, 64'd1);
      chk("zero_we", {63'd0, regWrite}, 64'd0);
      chk("zero_addr", {59'd0, writeAddress}, 64'd31);

      // hold with both valid
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b1, 5'd4, 64'h44, 1'b1, 5'd5, 64'h55);
      end
      chk("hold_count", {56'd0, conflictCount}, 64'd4);
      step(1'b1, 1'b0, 1'b1, 5'd4, 64'h44, 1'b1, 5'd5, 64'h55);
      chk("hold_release_grant1", {63'd0, obs1}, 64'd1);
      chk("hold_release_addr", {59'd0, writeAddress}, 64'd5);

      // saturation
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 1'b0, 1'b1, 5'd9, 64'(i), 1'b1, 5'd10, 64'(i) + 64'h1000);
      end
      chk("sat_count", {56'd0, conflictCount}, 64'd255);
      step(1'b1, 1'b0, 1'b1, 5'd9, 64'h1, 1'b1, 5'd10, 64'h2);
      chk("sat_hold_255", {56'd0, conflictCount}, 64'd255);
      idle();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
